// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Optional feature macro: FETCH_HALT_EN (adds the HALTED state).
package fetch_unit_pkg;

  localparam int PC_INCR    = 4;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 11'h7FF;

  typedef enum logic [1:0] {
    FETCH_ST_FETCH  = 2'd0,
    FETCH_ST_DRAIN  = 2'd1
`ifdef FETCH_HALT_EN
    ,
    FETCH_ST_HALTED = 2'd2
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {pc, instr} pairs feeding decode.
// Flush dominates push and pop; head outputs read the oldest entry.
module fetch_fifo #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [ADDR_W-1:0]  pushPc_i,
  input  logic [INSTR_W-1:0] pushInstr_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [1:0]         count_o,
  output logic [ADDR_W-1:0]  headPc_o,
  output logic [INSTR_W-1:0] headInstr_o
);

  logic [ADDR_W-1:0]  pc_q    [2];
  logic [INSTR_W-1:0] instr_q [2];
  logic               rdPtr_q, rdPtr_d;
  logic               wrPtr_q, wrPtr_d;
  logic [1:0]         count_q, count_d;
  logic               doPush, doPop;

  // Work out pointer and occupancy updates; a full buffer never accepts a push
  always_comb begin
    doPush  = push_i && (count_q != 2'd2);
    doPop   = pop_i && (count_q != 2'd0);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = 1'b0;
      wrPtr_d = 1'b0;
      count_d = 2'd0;
    end else begin
      if (doPush) wrPtr_d = ~wrPtr_q;
      if (doPop)  rdPtr_d = ~rdPtr_q;
      count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
    end
  end

  // Storage and pointer registers; entries clear on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (doPush && !flush_i) begin
        pc_q[wrPtr_q]    <= pushPc_i;
        instr_q[wrPtr_q] <= pushInstr_i;
      end
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign headPc_o    = pc_q[rdPtr_q];
  assign headInstr_o = instr_q[rdPtr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks req/ack to instruction memory,
// and hands {pc, instr, opcode} to decode through a two-entry buffer.
// Optional feature macro: FETCH_HALT_EN (halt on HALT_OPCODE, adds 'halted').
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   ADDR_W      = 64,
  parameter int                   INSTR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [OPCODE_W-1:0] out_opcode
`ifdef FETCH_HALT_EN
  ,
  output logic                halted
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pendingPc_q, pendingPc_d;
  logic              active_q;
  logic [1:0]        fifoCount;
  logic              fifoPush, fifoPop, fifoFlush;
  logic              ackFire;

  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifoPush),
    .pushPc_i    (pc_q),
    .pushInstr_i (imem_rdata),
    .pop_i       (fifoPop),
    .flush_i     (fifoFlush),
    .count_o     (fifoCount),
    .headPc_o    (out_pc),
    .headInstr_o (out_instr)
  );

  // State, PC and the deferred redirect target; active_q keeps req low while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_ST_FETCH;
      pc_q        <= RESET_PC;
      pendingPc_q <= RESET_PC;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pendingPc_q <= pendingPc_d;
      active_q    <= 1'b1;
    end
  end

  // Request generation and next-state; a redirect overrides everything else
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pendingPc_d = pendingPc_q;
    fifoPush    = 1'b0;
    fifoFlush   = 1'b0;
    imem_req    = 1'b0;
    case (state_q)
      FETCH_ST_FETCH: imem_req = active_q && (fifoCount < 2'd2);
      FETCH_ST_DRAIN: imem_req = 1'b1;
      default:        imem_req = 1'b0;
    endcase
    ackFire = imem_ack && imem_req;

    if (redirect_valid) begin
      fifoFlush = 1'b1;
      if (imem_req && !ackFire) begin
        state_d     = FETCH_ST_DRAIN;
        pendingPc_d = redirect_pc;
      end else begin
        state_d = FETCH_ST_FETCH;
        pc_d    = redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH_ST_FETCH: begin
          if (ackFire) begin
            fifoPush = 1'b1;
            pc_d     = pc_q + ADDR_W'(PC_INCR);
`ifdef FETCH_HALT_EN
            if (imem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
              state_d = FETCH_ST_HALTED;
            end
`endif
          end
        end
        FETCH_ST_DRAIN: begin
          if (ackFire) begin
            state_d = FETCH_ST_FETCH;
            pc_d    = pendingPc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifoPop    = out_valid && out_ready;
  assign imem_addr  = pc_q;
  assign out_valid  = (fifoCount != 2'd0);
  assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];

`ifdef FETCH_HALT_EN
  assign halted = (state_q == FETCH_ST_HALTED);
`else
  // HALT_OPCODE has no role without the halt feature; fold it into a sink
  logic unusedHaltOpcode;
  assign unusedHaltOpcode = ^HALT_OPCODE;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner-case
// sequences and a randomized run against a queue-based reference model.
// Build with FETCH_HALT_EN defined to also exercise the halt sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirectValid;
  logic [63:0] redirectPc;
  logic        out_valid;
  logic        outReady;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [10:0] out_opcode;
`ifdef FETCH_HALT_EN
  logic        halted;
`endif

  logic        tieAck;
  logic        haltInject;
  logic        ackDrv;
  logic [31:0] rdataDrv;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return {a[10:0] ^ 11'h2AA, a[22:2]};
  endfunction

  function automatic logic [31:0] memSel(input logic [63:0] a, input logic inj);
    if (inj && a == 64'h108) return 32'hFFE00000;
    return memWord(a);
  endfunction

  assign imem_ack   = tieAck ? imem_req : ackDrv;
  assign imem_rdata = tieAck ? memSel(imem_addr, haltInject) : rdataDrv;

  fetch_unit #(
    .RESET_PC (64'h100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .out_valid      (out_valid),
    .out_ready      (outReady),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode)
`ifdef FETCH_HALT_EN
    ,
    .halted         (halted)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Check the head entry against a known PC (instruction derived from the memory image)
  task automatic checkHead(input string name, input logic [63:0] pc);
    logic [31:0] w;
    w = memWord(pc);
    checkOutput({name, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({name, "_pc"}, out_pc, pc);
    checkOutput({name, "_instr"}, 64'(out_instr), 64'(w));
    checkOutput({name, "_opcode"}, 64'(out_opcode), 64'(w[31:21]));
  endtask

  // Assert reset, check the reset outputs, release and let one edge pass
  task automatic applyStimulus();
    @(negedge clk);
    rst_n = 1'b0;
    tieAck = 1'b0; ackDrv = 1'b0; rdataDrv = '0; haltInject = 1'b0;
    redirectValid = 1'b0; redirectPc = '0; outReady = 1'b0;
    #1;
    checkOutput("rst_req", 64'(imem_req), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_pc", out_pc, 64'd0);
    checkOutput("rst_instr", 64'(out_instr), 64'd0);
`ifdef FETCH_HALT_EN
    checkOutput("rst_halted", 64'(halted), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ready;
    logic        expReq;
    logic [63:0] expAddr;
    logic        expValid;
    logic [63:0] expPc;
  } vec_t;

  vec_t vecs[9];

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [63:0] mPc, mPend;
  bit          mDrain, mHalt, expReq, mAck, mPop;
  bit          busy;
  int          waitLeft;

  initial begin
    rst_n = 1'b1;
    tieAck = 1'b0; ackDrv = 1'b0; rdataDrv = '0; haltInject = 1'b0;
    redirectValid = 1'b0; redirectPc = '0; outReady = 1'b0;

    // ready, req, addr, valid, head pc
    vecs[0] = '{1'b0, 1'b1, 64'h100, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 64'h104, 1'b1, 64'h100};
    vecs[2] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100};
    vecs[3] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100};
    vecs[4] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h100};
    vecs[5] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h100};
    vecs[6] = '{1'b1, 1'b1, 64'h108, 1'b1, 64'h104};
    vecs[7] = '{1'b1, 1'b1, 64'h10C, 1'b1, 64'h108};
    vecs[8] = '{1'b1, 1'b1, 64'h110, 1'b1, 64'h10C};

    // Zero-wait memory with decode stalled, then released
    applyStimulus();
    tieAck = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(vecs[i].expReq));
      if (vecs[i].expReq) checkOutput($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].expAddr);
      if (vecs[i].expValid) checkHead($sformatf("tbl%0d", i), vecs[i].expPc);
      else checkOutput($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd0);
      outReady = vecs[i].ready;
      @(negedge clk);
    end

    // Slow ack with a redirect in the middle of the wait
    applyStimulus();
    outReady = 1'b1;
    checkOutput("slow_n0_addr", imem_addr, 64'h100);
    @(negedge clk);
    checkOutput("slow_n1_req", 64'(imem_req), 64'd1);
    redirectValid = 1'b1; redirectPc = 64'h400;
    @(negedge clk);
    redirectValid = 1'b0;
    checkOutput("slow_n2_addr", imem_addr, 64'h100);
    checkOutput("slow_n2_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("slow_n3_req", 64'(imem_req), 64'd1);
    checkOutput("slow_n3_addr", imem_addr, 64'h100);
    ackDrv = 1'b1; rdataDrv = memWord(64'h100);
    @(negedge clk);
    checkOutput("slow_n4_valid", 64'(out_valid), 64'd0);
    checkOutput("slow_n4_addr", imem_addr, 64'h400);
    rdataDrv = memWord(64'h400);
    @(negedge clk);
    ackDrv = 1'b0;
    checkHead("slow_n5", 64'h400);

    // Redirect coinciding with an ack while one word is buffered
    applyStimulus();
    tieAck = 1'b1; outReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("racc_addr", imem_addr, 64'h10C);
    checkHead("racc_head", 64'h108);
    tieAck = 1'b0; ackDrv = 1'b1; rdataDrv = memWord(64'h10C);
    redirectValid = 1'b1; redirectPc = 64'h200;
    @(negedge clk);
    redirectValid = 1'b0;
    checkOutput("racc_flush_valid", 64'(out_valid), 64'd0);
    checkOutput("racc_new_addr", imem_addr, 64'h200);
    rdataDrv = memWord(64'h200);
    @(negedge clk);
    ackDrv = 1'b0;
    checkHead("racc_new", 64'h200);

    // Reset dropped on a full buffer between clock edges
    applyStimulus();
    tieAck = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mrst_full_req", 64'(imem_req), 64'd0);
    checkOutput("mrst_full_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst_req", 64'(imem_req), 64'd0);
    checkOutput("mrst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mrst_restart_req", 64'(imem_req), 64'd1);
    checkOutput("mrst_restart_addr", imem_addr, 64'h100);
    tieAck = 1'b0;

`ifdef FETCH_HALT_EN
    // Halt opcode delivered, fetching stops, redirect resumes
    applyStimulus();
    tieAck = 1'b1; haltInject = 1'b1; outReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("halt_pc", out_pc, 64'h108);
    checkOutput("halt_opcode", 64'(out_opcode), 64'h7FF);
    checkOutput("halt_flag", 64'(halted), 64'd1);
    checkOutput("halt_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    checkOutput("halt_idle_req", 64'(imem_req), 64'd0);
    tieAck = 1'b0; haltInject = 1'b0;
    redirectValid = 1'b1; redirectPc = 64'h0;
    @(negedge clk);
    redirectValid = 1'b0;
    checkOutput("unhalt_flag", 64'(halted), 64'd0);
    checkOutput("unhalt_req", 64'(imem_req), 64'd1);
    checkOutput("unhalt_addr", imem_addr, 64'h0);
`endif

    // Randomized traffic against the queue-based model
    applyStimulus();
    mq.delete();
    mPc = 64'h100; mPend = '0; mDrain = 0; mHalt = 0;
    busy = 0; waitLeft = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      expReq = mHalt ? 1'b0 : (mDrain ? 1'b1 : (mq.size() < 2));
      checkOutput("rnd_req", 64'(imem_req), 64'(expReq));
      if (expReq) checkOutput("rnd_addr", imem_addr, mPc);
      checkOutput("rnd_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        checkOutput("rnd_pc", out_pc, mq[0].pc);
        checkOutput("rnd_instr", 64'(out_instr), 64'(mq[0].instr));
      end

      // Memory responder with random latency
      if (!imem_req) begin
        busy = 0; ackDrv = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1;
          waitLeft = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
        if (waitLeft == 0) begin
          ackDrv = 1'b1; busy = 0;
        end else begin
          ackDrv = 1'b0; waitLeft--;
        end
      end
      rdataDrv      = memWord(imem_addr);
      outReady      = ($urandom_range(0, 9) < 7);
      redirectValid = ($urandom_range(0, 11) == 0);
      redirectPc    = 64'($urandom_range(0, 1023)) << 2;

      // Model: what the stage should do on the coming edge
      mAck = ackDrv && expReq;
      mPop = (mq.size() != 0) && outReady;
      if (redirectValid) begin
        mq.delete();
        if (expReq && !mAck) begin
          mDrain = 1; mPend = redirectPc;
        end else begin
          mDrain = 0; mHalt = 0; mPc = redirectPc;
        end
      end else begin
        if (mPop) void'(mq.pop_front());
        if (mDrain && mAck) begin
          mDrain = 0; mPc = mPend;
        end else if (!mDrain && !mHalt && mAck) begin
          mq.push_back('{mPc, rdataDrv});
          mPc = mPc + 64'd4;
`ifdef FETCH_HALT_EN
          if (rdataDrv[31:21] == 11'h7FF) mHalt = 1;
`endif
        end
      end
      @(negedge clk);
    end
    redirectValid = 1'b0; ackDrv = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
